// File: rtl/fifo_pkt_pkg.sv
// Shared parameters, state encoding and helpers for the rx FIFO packet reader.
package fifo_pkt_pkg;

  localparam int unsigned DW         = 16;
  localparam int unsigned PKT_WORDS  = 256;
  localparam int unsigned MAX_CH     = 8;
  localparam int unsigned RD_LAT     = 1;
  localparam int unsigned CH_W       = $clog2(MAX_CH);
  localparam int unsigned CNT_W      = $clog2(PKT_WORDS) + 1;
  localparam int unsigned CHIN_W     = 4;
  localparam int unsigned SKID_DEPTH = RD_LAT + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Clamp a requested channel count into the legal range 1..MAX_CH.
  function automatic logic [CHIN_W-1:0] eff_channels(input logic [CHIN_W-1:0] ch);
    if (ch == '0) return CHIN_W'(1);
    if (ch > CHIN_W'(MAX_CH)) return CHIN_W'(MAX_CH);
    return ch;
  endfunction

endpackage

// File: rtl/pkt_skid_buf.sv
// Small synchronous FIFO that absorbs words returned while the output is stalled.
module pkt_skid_buf #(
  parameter  int unsigned W     = 16,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  head_c,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fifo_packet_reader.sv
// Bursts one packet out of the rx sample FIFO and emits it as a tagged,
// back-pressured sample stream with channel index, sop and eop.
module fifo_packet_reader
  import fifo_pkt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [CHIN_W-1:0] channels,
  input  logic              packet_rdy,
  output logic              rd_req,
  input  logic [DW-1:0]     din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_sop,
  output logic              out_eop,
  output logic              busy,
  output logic [15:0]       pkt_count,
  output logic              ch_err,
  input  logic              clear_err
);

  localparam int unsigned SKID_CW = $clog2(SKID_DEPTH + 1);
  localparam int unsigned PEND_W  = $clog2(SKID_DEPTH + RD_LAT + 1);

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    issued_cnt;
  logic [CNT_W-1:0]    ld_cnt;
  logic [CH_W-1:0]     ld_ch;
  logic [CHIN_W-1:0]   eff_ch;
  logic [RD_LAT-1:0]   vpipe;
  logic [SKID_CW-1:0]  skid_count;
  logic [DW-1:0]       skid_head_c;
  logic [DW-1:0]       load_data;
  logic [PEND_W-1:0]   inflight;
  logic [PEND_W-1:0]   pending;
  logic                din_valid;
  logic                accept;
  logic                load_ok;
  logic                load;
  logic                skid_push;
  logic                skid_pop;
  logic                start;

  pkt_skid_buf #(
    .W     (DW),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .push   (skid_push),
    .wdata  (din),
    .pop    (skid_pop),
    .head_c (skid_head_c),
    .count  (skid_count)
  );

  // Returned words bypass the skid when it is empty and the output can take them.
  always_comb begin
    din_valid = vpipe[RD_LAT-1];
    accept    = out_valid && out_ready;
    load_ok   = !out_valid || out_ready;
    skid_pop  = load_ok && (skid_count != '0);
    skid_push = din_valid && !(load_ok && (skid_count == '0));
    load      = load_ok && ((skid_count != '0) || din_valid);
    load_data = (skid_count != '0) ? skid_head_c : din;
    start     = (state == IDLE) && packet_rdy;
  end

  // Issue only while every outstanding word is guaranteed a skid slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + PEND_W'(vpipe[i]);
    pending = PEND_W'(skid_count) + inflight;
    rd_req  = !reset && (state == READ) && (issued_cnt < CNT_W'(PKT_WORDS))
              && (pending < PEND_W'(SKID_DEPTH));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (packet_rdy) state_next = READ;
      READ:    if (issued_cnt == CNT_W'(PKT_WORDS)) state_next = DRAIN;
      DRAIN:   if (accept && out_eop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      issued_cnt <= '0;
      ld_cnt     <= '0;
      ld_ch      <= '0;
      eff_ch     <= CHIN_W'(1);
      vpipe      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      pkt_count  <= '0;
      ch_err     <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      vpipe <= RD_LAT'({vpipe, rd_req});

      if (start) begin
        issued_cnt <= '0;
        ld_cnt     <= '0;
        ld_ch      <= '0;
        eff_ch     <= eff_channels(channels);
      end else begin
        if (rd_req) issued_cnt <= issued_cnt + CNT_W'(1);
        if (load) begin
          ld_cnt <= ld_cnt + CNT_W'(1);
          ld_ch  <= (CHIN_W'(ld_ch) == eff_ch - CHIN_W'(1)) ? '0 : ld_ch + CH_W'(1);
        end
      end

      // Tags are attached as words enter the output register, in stream order.
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_ch    <= ld_ch;
        out_sop   <= (ld_cnt == '0);
        out_eop   <= (ld_cnt == CNT_W'(PKT_WORDS - 1));
      end else if (accept) begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
      end

      if (accept && out_eop) pkt_count <= pkt_count + 16'd1;

      ch_err <= (start && ((channels == '0) || (channels > CHIN_W'(MAX_CH))))
                || (ch_err && !clear_err);
    end
  end

endmodule

// File: tb/tb_fifo_packet_reader.sv
// Self-checking bench: FIFO source model, word scoreboard and per-packet tag model.
module tb_fifo_packet_reader;
  import fifo_pkt_pkg::*;

  logic              clk;
  logic              reset;
  logic [CHIN_W-1:0] channels;
  logic              packet_rdy;
  logic              rd_req;
  logic [DW-1:0]     din;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [CH_W-1:0]   out_ch;
  logic              out_sop;
  logic              out_eop;
  logic              busy;
  logic [15:0]       pkt_count;
  logic              ch_err;
  logic              clear_err;

  fifo_packet_reader dut (
    .clk        (clk),
    .reset      (reset),
    .channels   (channels),
    .packet_rdy (packet_rdy),
    .rd_req     (rd_req),
    .din        (din),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .busy       (busy),
    .pkt_count  (pkt_count),
    .ch_err     (ch_err),
    .clear_err  (clear_err)
  );

  typedef struct {
    logic [CHIN_W-1:0] ch;
    int                eff;
    logic              err;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fifo_word = '0;
  logic [DW-1:0] mon_w;
  int          req_cnt = 0;
  int          idx = 0;
  logic [15:0] exp_pkts = '0;
  int          exp_eff = 1;
  bit          mon_en = 0;
  bit          stall = 0;
  bit          rnd_ready = 0;
  bit          ready_fixed = 1;
  bit          gap_wait = 0;
  bit          src_req;
  bit          src_rst;
  logic [DW-1:0]   held_data;
  logic [CH_W-1:0] held_ch;
  logic [CH_W-1:0] last_eop_ch = '0;
  int          eop_cyc = 0;
  int          first_req_cyc = 0;
  int          max_skid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic int ref_eff(input int ch);
    if (ch == 0) return 1;
    if (ch > int'(MAX_CH)) return int'(MAX_CH);
    return ch;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // FIFO read port: a word appears one cycle after each sampled rd_req.
  always begin
    @(negedge clk);
    src_req = (rd_req === 1'b1);
    src_rst = (reset !== 1'b0);
    if (src_req && !src_rst) begin
      req_cnt++;
      if (gap_wait) begin
        first_req_cyc = cyc;
        gap_wait = 0;
      end
    end
    @(posedge clk);
    #1;
    if (src_rst) exp_q.delete();
    else if (src_req) begin
      din = fifo_word;
      exp_q.push_back(fifo_word);
      fifo_word = fifo_word + 16'd1;
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  // Scoreboard: words leave in FIFO order; tags follow the word's packet index.
  always @(negedge clk) begin
    if (mon_en) begin
      check("pkt_count", 32'(pkt_count), 32'(exp_pkts));
      if (int'(dut.u_skid.count) > max_skid) max_skid = int'(dut.u_skid.count);
      if (reset) begin
        idx = 0;
        exp_pkts = '0;
        stall = 0;
      end else begin
        if (stall) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'(out_data), 32'(held_data));
          check("hold_ch", 32'(out_ch), 32'(held_ch));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got data %0d with no word outstanding", out_data);
          end else begin
            mon_w = exp_q.pop_front();
            check("data", 32'(out_data), 32'(mon_w));
          end
          check("ch", 32'(out_ch), 32'(idx % exp_eff));
          check("sop", 32'(out_sop), 32'(idx == 0));
          check("eop", 32'(out_eop), 32'(idx == int'(PKT_WORDS) - 1));
          if (idx == int'(PKT_WORDS) - 1) begin
            exp_pkts = exp_pkts + 16'd1;
            last_eop_ch = out_ch;
            eop_cyc = cyc;
            gap_wait = 1;
            idx = 0;
          end else idx++;
          stall = 0;
        end else if (out_valid) begin
          stall = 1;
          held_data = out_data;
          held_ch = out_ch;
        end else stall = 0;
      end
    end
  end

  task automatic wait_pkts(input int n, input string name);
    int t;
    t = 0;
    while (pkt_count !== 16'(n) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(pkt_count), 32'(n));
  endtask

  task automatic wait_idx(input int n);
    int t;
    t = 0;
    while (idx < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("reach_word", 32'(idx >= n), 32'd1);
  endtask

  task automatic pulse_rdy();
    @(posedge clk); #1 packet_rdy = 1'b1;
    @(posedge clk); #1 packet_rdy = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_err = 1'b1;
    @(posedge clk); #1 clear_err = 1'b0;
    @(negedge clk);
    check("clear_err", 32'(ch_err), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    int   lat;
    int   npk;
    int   c;

    vecs[0] = '{4'd1,  1, 1'b0};
    vecs[1] = '{4'd4,  4, 1'b0};
    vecs[2] = '{4'd0,  1, 1'b1};
    vecs[3] = '{4'd9,  8, 1'b1};
    vecs[4] = '{4'd8,  8, 1'b0};
    vecs[5] = '{4'd7,  7, 1'b0};
    vecs[6] = '{4'd15, 8, 1'b1};

    reset = 1'b1; channels = 4'd1; packet_rdy = 1'b0; clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sop", 32'(out_sop), 32'd0);
    check("rst_out_eop", 32'(out_eop), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    check("rst_ch_err", 32'(ch_err), 32'd0);
    mon_en = 1;

    // One channel, single packet_rdy pulse, latency and read count.
    exp_eff = 1; channels = 4'd1; req_cnt = 0; lat = -1;
    @(posedge clk); #1 packet_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_active", 32'(busy), 32'd1);
      if (out_valid && lat < 0) lat = k;
      @(posedge clk); #1 packet_rdy = 1'b0;
    end
    check("first_word_latency", 32'(lat), 32'(RD_LAT + 2));
    wait_pkts(1, "t1_pkts");
    check("t1_rd_req_cycles", 32'(req_cnt), 32'(PKT_WORDS));
    @(negedge clk);
    check("t1_busy_done", 32'(busy), 32'd0);

    // Four channels, back-to-back packets with one idle cycle between them.
    exp_eff = 4; channels = 4'd4; req_cnt = 0;
    @(posedge clk); #1 packet_rdy = 1'b1;
    wait_pkts(2, "t2_first");
    @(posedge clk); #1 packet_rdy = 1'b0;
    @(negedge clk); @(negedge clk);
    check("t2_eop_to_rd_req", 32'(first_req_cyc - eop_cyc), 32'd2);
    wait_pkts(3, "t2_second");
    check("t2_rd_req_cycles", 32'(req_cnt), 32'(2 * PKT_WORDS));

    // Three channels under random back-pressure.
    exp_eff = 3; channels = 4'd3; rnd_ready = 1; max_skid = 0;
    pulse_rdy();
    wait_pkts(4, "t3_pkts");
    check("t3_last_word_ch", 32'(last_eop_ch), 32'd0);
    check("t3_skid_bound", 32'(max_skid <= int'(SKID_DEPTH)), 32'd1);
    npk = 4;

    // Random channel counts, still under random back-pressure.
    for (int r = 0; r < 3; r++) begin
      c = int'($urandom_range(0, 15));
      channels = 4'(c); exp_eff = ref_eff(c);
      pulse_clear();
      pulse_rdy();
      @(negedge clk);
      check("rnd_ch_err", 32'(ch_err), 32'(c == 0 || c > int'(MAX_CH)));
      npk++;
      wait_pkts(npk, "rnd_pkts");
    end
    rnd_ready = 0; ready_fixed = 1;

    // Table of channel counts including clamped values.
    for (int v = 0; v < 7; v++) begin
      pulse_clear();
      channels = vecs[v].ch; exp_eff = vecs[v].eff;
      pulse_rdy();
      @(negedge clk);
      check("vec_ch_err", 32'(ch_err), 32'(vecs[v].err));
      npk++;
      wait_pkts(npk, "vec_pkts");
    end

    // clear_err colliding with a fresh channel error keeps the flag set.
    channels = 4'd0; exp_eff = 1;
    @(posedge clk); #1 packet_rdy = 1'b1; clear_err = 1'b1;
    @(posedge clk); #1 packet_rdy = 1'b0; clear_err = 1'b0;
    @(negedge clk);
    check("err_clear_collide", 32'(ch_err), 32'd1);
    npk++;
    wait_pkts(npk, "collide_pkts");

    // Reset in the middle of a packet, then a clean restart.
    channels = 4'd0; exp_eff = 1;
    pulse_rdy();
    wait_idx(100);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_rd_req", 32'(rd_req), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_sop", 32'(out_sop), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_out_ch", 32'(out_ch), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
    check("mid_rst_ch_err", 32'(ch_err), 32'd0);
    channels = 4'd2; exp_eff = 2;
    pulse_rdy();
    wait_pkts(1, "post_rst_pkts");

    // packet_rdy dropped mid-packet, then held high for the next one.
    channels = 4'd5; exp_eff = 5; req_cnt = 0; first_req_cyc = 0;
    @(posedge clk); #1 packet_rdy = 1'b1;
    wait_idx(10);
    @(posedge clk); #1 packet_rdy = 1'b0;
    repeat (20) @(posedge clk);
    #1 packet_rdy = 1'b1;
    wait_pkts(2, "t6_first");
    @(posedge clk); #1 packet_rdy = 1'b0;
    @(negedge clk); @(negedge clk);
    check("t6_eop_to_rd_req", 32'(first_req_cyc - eop_cyc), 32'd2);
    wait_pkts(3, "t6_second");
    check("t6_rd_req_cycles", 32'(req_cnt), 32'(2 * PKT_WORDS));
    repeat (4) @(negedge clk);
    check("final_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
